// File: rtl/i2c_slave.sv
// Byte-oriented I2C target: oversampled SCL/SDA, START/STOP detection, fixed address, read/write bytes.
// Optional `I2C_SLAVE_GLITCH_FILTER_EN adds a 3-tap majority filter on both bus lines.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic       ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] shreg, shreg_nxt, rx_data_nxt;
    logic       sda_low, sda_low_nxt, busy_nxt, rx_valid_nxt, tx_load_nxt;
    logic       scl_s1, scl_s2, sda_s1, sda_s2, scl_f, sda_f;
    logic       scl_r, scl_d, sda_r, sda_d;

    // Release is combinational on reset so the bus is freed without waiting for an edge.
    assign i2c_sda = (sda_low && !reset) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_s1, scl_s2, sda_s1, sda_s2} <= '1;
        end else begin
            scl_s1 <= i2c_scl;
            scl_s2 <= scl_s1;
            sda_s1 <= i2c_sda;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;
    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_h, sda_h, scl_f, sda_f} <= '1;
        end else begin
            scl_h <= {scl_h[0], scl_s2};
            sda_h <= {sda_h[0], sda_s2};
            scl_f <= (scl_s2 & scl_h[0]) | (scl_s2 & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda_f <= (sda_s2 & sda_h[0]) | (sda_s2 & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_r, scl_d, sda_r, sda_d} <= '1;
        end else begin
            scl_r <= scl_f;
            scl_d <= scl_r;
            sda_r <= sda_f;
            sda_d <= sda_r;
        end
    end

    logic       scl_rise, scl_fall, start_det, stop_det, addr_hit;
    logic [7:0] shift_in;
    assign scl_rise  = scl_r & ~scl_d;
    assign scl_fall  = ~scl_r & scl_d;
    assign start_det = scl_r & scl_d & sda_d & ~sda_r;
    assign stop_det  = scl_r & scl_d & ~sda_d & sda_r;
    assign addr_hit  = (shreg[7:1] == SLAVE_ADDR);
    assign shift_in  = {shreg[6:0], sda_r};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            sda_low  <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shreg    <= shreg_nxt;
            sda_low  <= sda_low_nxt;
            busy     <= busy_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            tx_load  <= tx_load_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop_det)       state_nxt = IDLE;
        else if (start_det) state_nxt = ADDR;
        else begin
            case (state)
                ADDR:     if (scl_fall && cnt == 4'd8) state_nxt = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) state_nxt = shreg[0] ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_fall && cnt == 4'd8) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = sda_low ? WR_DATA : IGNORE;
                RD_DATA:  if (scl_fall && cnt == 4'd7) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_r)              state_nxt = IGNORE;
                    else if (scl_fall && cnt == 4'd1)   state_nxt = RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        sda_low_nxt  = sda_low;
        busy_nxt     = busy;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        tx_load_nxt  = 1'b0;
        // The read byte lands one cycle after the request, along with its first bit.
        if (tx_load) begin
            shreg_nxt   = tx_data;
            sda_low_nxt = ~tx_data[7];
        end
        if (stop_det) begin
            cnt_nxt     = '0;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else if (start_det) begin
            cnt_nxt     = '0;
            sda_low_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && cnt < 4'd8) begin
                        shreg_nxt = shift_in;
                        cnt_nxt   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_nxt     = '0;
                        sda_low_nxt = addr_hit;
                        busy_nxt    = addr_hit;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    cnt_nxt     = '0;
                    sda_low_nxt = 1'b0;
                    tx_load_nxt = shreg[0];
                end
                WR_DATA: begin
                    if (scl_rise && cnt < 4'd8) begin
                        shreg_nxt = shift_in;
                        cnt_nxt   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            rx_data_nxt  = shift_in;
                            rx_valid_nxt = 1'b1;
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_nxt     = '0;
                        sda_low_nxt = ack_en;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    cnt_nxt     = '0;
                    sda_low_nxt = 1'b0;
                    if (!sda_low) busy_nxt = 1'b0;
                end
                RD_DATA: if (scl_fall) begin
                    shreg_nxt   = {shreg[6:0], 1'b0};
                    cnt_nxt     = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                    sda_low_nxt = (cnt == 4'd7) ? 1'b0 : ~shreg[6];
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_r) busy_nxt = 1'b0;
                        else       cnt_nxt  = 4'd1;
                    end else if (scl_fall && cnt == 4'd1) begin
                        cnt_nxt     = '0;
                        tx_load_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master on a pulled-up open-drain bus.
module tb_i2c_slave;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 0, reset = 1, scl = 1, m_sda_low = 0, ack_en = 1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load, rx_valid, busy;
    logic [7:0] rx_data;
    wire        sda;
    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    int total = 0, bad = 0;
    int rxv_cnt = 0, txl_cnt = 0;
    logic busy_seen = 0, slave_drove = 0;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda), .ack_en(ack_en),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (tx_load) txl_cnt++;
        if (busy) busy_seen = 1;
        if (sda === 1'b0 && !m_sda_low) slave_drove = 1;
    end

    task automatic wq(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic clr_mon();
        rxv_cnt = 0; txl_cnt = 0; busy_seen = 0; slave_drove = 0;
    endtask

    task automatic bus_start();
        m_sda_low = 0; wq(); scl = 1; wq(); m_sda_low = 1; wq(); scl = 0; wq();
    endtask

    task automatic bus_stop();
        m_sda_low = 1; wq(); scl = 1; wq(); m_sda_low = 0; wq(2);
    endtask

    task automatic send_bit(input logic b, output logic rb);
        m_sda_low = !b; wq(); scl = 1; wq(); rb = sda; wq(); scl = 0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) send_bit(d[i], rb);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic rb;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, rb);
            d = {d[6:0], rb};
        end
        send_bit(!m_ack, rb);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1", sda); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (tx_load !== 1'b0) begin bad++; $display("FAIL reset_tx_load: got %b want 0", tx_load); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 0;
        wq(2);
    endtask

    task automatic test_write();
        logic a;
        clr_mon(); ack_en = 1;
        bus_start();
        send_byte(8'hA0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_addr_ack: got %b want 0", a); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", busy); end
        send_byte(8'hA5, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_data_ack: got %b want 0", a); end
        bus_stop();
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL wr_rx_valid_count: got %0d want 1", rxv_cnt); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL wr_rx_data: got %h want a5", rx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL wr_sda_released: got %b want 1", sda); end
    endtask

    task automatic test_addr_miss();
        logic a;
        clr_mon();
        bus_start();
        send_byte(8'hA2, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL miss_ack: got %b want 1", a); end
        bus_stop();
        total++; if (slave_drove !== 1'b0) begin bad++; $display("FAIL miss_sda_driven: got %b want 0", slave_drove); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL miss_busy: got %b want 0", busy_seen); end
        total++; if (rxv_cnt !== 0) begin bad++; $display("FAIL miss_rx_valid: got %0d want 0", rxv_cnt); end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] d;
        clr_mon(); tx_data = 8'h3C;
        bus_start();
        send_byte(8'hA1, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_addr_ack: got %b want 0", a); end
        tx_data = 8'hC3;
        read_byte(1'b1, d);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL rd_byte0: got %h want 3c", d); end
        read_byte(1'b0, d);
        total++; if (d !== 8'hC3) begin bad++; $display("FAIL rd_byte1: got %h want c3", d); end
        total++; if (txl_cnt !== 2) begin bad++; $display("FAIL rd_tx_load_count: got %0d want 2", txl_cnt); end
        m_sda_low = 0; wq();
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rd_sda_after_nack: got %b want 1", sda); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_nack: got %b want 0", busy); end
        bus_stop();
    endtask

    task automatic test_data_nack();
        logic a;
        clr_mon(); ack_en = 0;
        bus_start();
        send_byte(8'hA0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL nack_addr_ack: got %b want 0", a); end
        send_byte(8'h11, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL nack_data_bit9: got %b want 1", a); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL nack_rx_data: got %h want 11", rx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nack_busy: got %b want 0", busy); end
        ack_en = 1;
        send_byte(8'h22, a);  // ignored after the NACK
        total++; if (a !== 1'b1) begin bad++; $display("FAIL nack_ignore_ack: got %b want 1", a); end
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL nack_rx_valid_count: got %0d want 1", rxv_cnt); end
        bus_stop();
    endtask

    task automatic test_rep_start();
        logic a, rb;
        clr_mon(); ack_en = 1;
        bus_start();
        send_byte(8'hA0, a);
        send_bit(1'b1, rb); send_bit(1'b0, rb); send_bit(1'b1, rb); send_bit(1'b1, rb);
        bus_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy_hold: got %b want 1", busy); end
        send_byte(8'hA0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rs_addr_ack: got %b want 0", a); end
        send_byte(8'h5A, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rs_data_ack: got %b want 0", a); end
        bus_stop();
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL rs_rx_valid_count: got %0d want 1", rxv_cnt); end
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rs_rx_data: got %h want 5a", rx_data); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        tx_data = 8'h00;
        bus_start();
        send_byte(8'hA1, a);
        total++; if (sda !== 1'b0) begin bad++; $display("FAIL rst_sda_driven: got %b want 0", sda); end
        reset = 1; #1;
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rst_sda_release: got %b want 1", sda); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
        total++; if (tx_load !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL rst_pulses: got %b%b want 00", tx_load, rx_valid); end
        reset = 0;
        wq();
        bus_stop();
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic a;
        bus_start();
        @(negedge clk); scl = 1; @(negedge clk); scl = 0;
        wq();
        send_byte(8'hA0, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL glitch_addr_ack: got %b want 0", a); end
        bus_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_addr_miss();
        test_read();
        test_data_nack();
        test_rep_start();
        test_reset_mid_read();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
